// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the PC, issues fetches and queues {pc, instr} pairs for decode.
// Latency: an issued address reaches inst_valid two cycles later; redirect target shows three cycles after the redirect.
// Backpressure: decode stalls via inst_ready; issue is credit-gated so returning words always find a free slot.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [31:0]              fetch_addr,
  input  logic [31:0]              fetch_data,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst_pc,
  output logic [31:0]              inst_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc_q, pc_d;
  logic          ifv_q, ifv_d;
  logic [31:0]   ifpc_q, ifpc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   mem_q [DEPTH];

  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   credit;
  logic [63:0]   head;

  // Handshake and credit decode: occupancy after this cycle plus the word still in flight
  always_comb begin
    head       = mem_q[rd_ptr_q];
    inst_valid = (count_q != '0) & ~redirect_valid;
    pop        = inst_valid & inst_ready;
    push       = ifv_q & ~redirect_valid;
    credit     = {1'b0, count_q} + {{CW{1'b0}}, ifv_q} - {{CW{1'b0}}, pop};
    issue      = ~redirect_valid & (credit < (CW+1)'(DEPTH));
    fetch_addr = pc_q;
    count      = count_q;
    inst_pc    = inst_valid ? head[63:32] : 32'h0;
    inst_data  = inst_valid ? head[31:0]  : 32'h0;
  end

  // Next-state: redirect flushes everything and reloads the PC; otherwise issue/push/pop
  always_comb begin
    pc_d     = pc_q;
    ifv_d    = 1'b0;
    ifpc_d   = ifpc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        pc_d   = pc_q + 32'd4;
        ifv_d  = 1'b1;
        ifpc_d = pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end
  end

  // Control state registers with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      ifv_q    <= 1'b0;
      ifpc_q   <= 32'h0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      ifv_q    <= ifv_d;
      ifpc_q   <= ifpc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage; contents need no reset because outputs are gated by inst_valid
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= {ifpc_q, fetch_data};
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: vector table for startup, full-queue and redirect,
// plus hand sequences for reset-over-redirect and PC wraparound.
module tb_fetch_ctrl;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: RESET_PC = 0
  logic        rst = 1'b1;
  logic [31:0] fetch_addr, fetch_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst_pc, inst_data;
  logic [2:0]  count;

  // DUT 1: RESET_PC near the top of the address space
  logic        rst1 = 1'b1;
  logic [31:0] fetch_addr1, fetch_data1;
  logic        inst_valid1;
  logic [31:0] inst_pc1, inst_data1;
  logic [2:0]  count1;

  fetch_ctrl #(.RESET_PC(32'h0), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_pc(inst_pc), .inst_data(inst_data), .count(count)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut1 (
    .clk(clk), .rst(rst1), .fetch_addr(fetch_addr1), .fetch_data(fetch_data1),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .inst_valid(inst_valid1), .inst_ready(1'b1),
    .inst_pc(inst_pc1), .inst_data(inst_data1), .count(count1)
  );

  // Registered fetch models
  always @(posedge clk) begin
    fetch_data  <= fetch_addr  ^ K;
    fetch_data1 <= fetch_addr1 ^ K;
  end

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        chk;
    logic        vld;
    logic [31:0] pc;
    int          cnt;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int failures = 0;

  task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                     input logic c, input logic vld, input logic [31:0] pc, input int cnt,
                     input logic [31:0] addr);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.chk = c;
    v.vld = vld; v.pc = pc; v.cnt = cnt; v.addr = addr;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    rst = r; inst_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    #1;
  endtask

  initial begin
    // Startup with decode always ready: no bubbles after the first word
    add(1,1,0,0, 0, 0,0,0,0);
    add(0,1,0,0, 1, 0,32'h0,0,32'h0);
    add(0,1,0,0, 1, 0,32'h0,0,32'h4);
    add(0,1,0,0, 1, 1,32'h0,1,32'h8);
    add(0,1,0,0, 1, 1,32'h4,1,32'hC);
    add(0,1,0,0, 1, 1,32'h8,1,32'h10);
    add(0,1,0,0, 1, 1,32'hC,1,32'h14);
    // Decode stalled from reset: fill, freeze, single-cycle pulse, release
    add(1,0,0,0, 0, 0,0,0,0);
    add(0,0,0,0, 1, 0,32'h0,0,32'h0);
    add(0,0,0,0, 1, 0,32'h0,0,32'h4);
    add(0,0,0,0, 1, 1,32'h0,1,32'h8);
    add(0,0,0,0, 1, 1,32'h0,2,32'hC);
    add(0,0,0,0, 1, 1,32'h0,3,32'h10);
    add(0,0,0,0, 1, 1,32'h0,4,32'h10);
    add(0,0,0,0, 1, 1,32'h0,4,32'h10);
    add(0,1,0,0, 1, 1,32'h0,4,32'h10);
    add(0,0,0,0, 1, 1,32'h4,3,32'h14);
    add(0,0,0,0, 1, 1,32'h4,4,32'h14);
    add(0,1,0,0, 1, 1,32'h4,4,32'h14);
    add(0,1,0,0, 1, 1,32'h8,3,32'h18);
    add(0,1,0,0, 1, 1,32'hC,3,32'h1C);
    add(0,1,0,0, 1, 1,32'h10,3,32'h20);
    add(0,1,0,0, 1, 1,32'h14,3,32'h24);
    add(0,1,0,0, 1, 1,32'h18,3,32'h28);
    // Three queued then redirect to 0x103 (aligned to 0x100)
    add(1,0,0,0, 0, 0,0,0,0);
    add(0,0,0,0, 1, 0,32'h0,0,32'h0);
    add(0,0,0,0, 1, 0,32'h0,0,32'h4);
    add(0,0,0,0, 1, 1,32'h0,1,32'h8);
    add(0,0,0,0, 1, 1,32'h0,2,32'hC);
    add(0,1,1,32'h103, 1, 0,32'h0,3,32'h10);
    add(0,1,0,0, 1, 0,32'h0,0,32'h100);
    add(0,1,0,0, 1, 0,32'h0,0,32'h104);
    add(0,1,0,0, 1, 1,32'h100,1,32'h108);
    add(0,1,0,0, 1, 1,32'h104,1,32'h10C);
    add(0,1,0,0, 1, 1,32'h108,1,32'h110);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
      if (tbl[i].chk) begin
        check("inst_valid", i, {31'h0, inst_valid}, {31'h0, tbl[i].vld});
        check("inst_pc",    i, inst_pc, tbl[i].vld ? tbl[i].pc : 32'h0);
        check("inst_data",  i, inst_data, tbl[i].vld ? (tbl[i].pc ^ K) : 32'h0);
        check("count",      i, {29'h0, count}, 32'(tbl[i].cnt));
        check("fetch_addr", i, fetch_addr, tbl[i].addr);
      end
    end

    // Reset and redirect together mid-stream: reset wins
    begin
      bit got = 0;
      drive(1,1,1,32'h200);
      drive(0,1,0,0);
      check("rstredir_addr",  0, fetch_addr, 32'h0);
      check("rstredir_count", 0, {29'h0, count}, 32'h0);
      check("rstredir_valid", 0, {31'h0, inst_valid}, 32'h0);
      for (int n = 0; n < 8 && !got; n++) begin
        drive(0,1,0,0);
        if (inst_valid) begin
          got = 1;
          check("rstredir_first_pc", n, inst_pc, 32'h0);
          check("rstredir_latency",  n, 32'(n), 32'd1);
        end
      end
      if (!got) begin
        checks++; failures++;
        $display("FAIL rstredir_timeout: got no inst_valid expected one within 8 cycles");
      end
    end

    // PC wraparound on the second instance
    begin
      logic [31:0] exp_pc [4];
      int n_got = 0;
      exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC;
      exp_pc[2] = 32'h0000_0000; exp_pc[3] = 32'h0000_0004;
      @(negedge clk); rst1 = 1'b1;
      @(negedge clk); rst1 = 1'b0; #1;
      check("wrap_reset_addr", 0, fetch_addr1, 32'hFFFF_FFF8);
      for (int n = 0; n < 20 && n_got < 4; n++) begin
        if (inst_valid1) begin
          check("wrap_pc",   n_got, inst_pc1, exp_pc[n_got]);
          check("wrap_data", n_got, inst_data1, exp_pc[n_got] ^ K);
          n_got++;
        end
        @(negedge clk); #1;
      end
      if (n_got < 4) begin
        checks++; failures++;
        $display("FAIL wrap_timeout: got %0d words expected 4", n_got);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
